brq_fp_wb_arbiter: RTL and testbench
====================================

Name: brq_fp_wb_arbiter

Overview:
Write-back stage directly upstream of the FP flip-flop register file. Merges two result sources, the FPU result and the LSU FP-load (FLW) data, onto the register file's single write port, with fair arbitration and a registered output. Also keeps a per-register pending scoreboard so the issue stage can stall on read-after-write hazards for the three FP read ports (rs1/rs2/rs3).

Parameters:
DataWidth, 32, width of FP data words; must match the register file DataWidth.
NumRegs, 32, number of FP architectural registers tracked; all are writable (f0 is not hard-wired).

Ports:
clk_i  input  1  clock; one clock domain
rst_i  input  1  reset; synchronous, active-high
fpu_valid_i  input  1  FPU result valid
fpu_ready_o  output  1  FPU result accepted this cycle
fpu_rd_i  input  5  FPU destination register
fpu_wdata_i  input  DataWidth  FPU result data
lsu_valid_i  input  1  FP load data valid
lsu_ready_o  output  1  FP load data accepted this cycle
lsu_rd_i  input  5  load destination register
lsu_wdata_i  input  DataWidth  load data
issue_valid_i  input  1  an FP-writing instruction issues this cycle
issue_rd_i  input  5  its destination register
rs_addr_i  input  3x5  rs1/rs2/rs3 addresses of the instruction in issue
rs_used_i  input  3  per-operand "operand is read" flags
hazard_o  output  1  some used operand is still pending
waddr_a_o  output  5  register file write address
wdata_a_o  output  DataWidth  register file write data
we_a_o  output  1  register file write enable
pending_o  output  NumRegs  scoreboard state, for debug and assertions

Behaviour:
- Reset (rst_i sampled high at a rising edge):
  - we_a_o=0, waddr_a_o=0, wdata_a_o=0, pending_q=0, rr_q=0 (FPU has priority next).
  - fpu_ready_o=lsu_ready_o=0 and hazard_o=0 while rst_i is high.
  - A reset mid-transfer discards any granted but unwritten result.
- Handshake is valid/ready. A transfer occurs when valid & ready at a rising edge. A source holds valid, rd and data stable until it is accepted. Ready is combinational from valid and rr_q.
- Arbitration (at most one grant per cycle):
  - Only one source valid: grant it.
  - Both valid: grant FPU if rr_q=0, else LSU.
  - After any grant, rr_q points to the other source. Uncontended grants also toggle rr_q.
  - Neither valid: no grant, rr_q holds.
- Output register: 1-cycle latency. At the edge where a transfer occurs, waddr/wdata/we_a_o load the winner's rd/data/1. With no transfer, we_a_o<=0 and waddr/wdata hold their last values. Back-to-back transfers give we_a_o high on consecutive cycles. Throughput is 1 write per cycle.
- Scoreboard pending_q[NumRegs-1:0]:
  - Set: issue_valid_i sets bit issue_rd_i.
  - Clear: we_a_o=1 clears bit waddr_a_o. The clear happens on the same edge the register file captures the data.
  - Set and clear on the same register in the same cycle: set wins.
  - Issue to an already-pending register: the bit stays 1. No counting is done; in-order issue guarantees a single outstanding writer per rd.
  - A write to a non-pending register is legal and leaves the bit 0.
- hazard_o = OR over k of (rs_used_i[k] & pending_q[rs_addr_i[k]]).
  - Purely combinational from the registered pending_q. No bypass.
  - A consumer becomes hazard-free on the cycle after we_a_o, when the register file already holds the new value.
- pending_o = pending_q.

Test Plan:
- Reset: assert rst_i for 2 cycles with both sources valid -> both readies 0, we_a_o=0, pending_o=0. After release, first grant goes to FPU.
- Single source: FPU valid with rd=5, data=0x41A00000 -> fpu_ready_o=1 that cycle. Next cycle we_a_o=1, waddr_a_o=5, wdata_a_o=0x41A00000. The cycle after, we_a_o=0.
- Contention: both sources held valid for 4 cycles (FPU rd=1, LSU rd=2, each taking new data after acceptance) -> grants alternate FPU, LSU, FPU, LSU. we_a_o stays high for 4 consecutive cycles with matching addresses.
- Scoreboard: issue rd=6; next cycle rs1=6 used -> hazard_o=1. LSU delivers rd=6 -> hazard_o stays 1 through the we_a_o cycle and drops to 0 the cycle after. With rs_used_i[0]=0, hazard_o=0 throughout.
- Simultaneous set/clear: issue rd=3 in the same cycle we_a_o writes rd=3 -> pending_o[3]=1 afterwards.
- Mid-operation reset: grant FPU rd=7 and assert rst_i on the next edge -> we_a_o=0 and the rd=7 write never appears. pending_o=0.

Source files
------------

// File: rtl/brq_fp_wb_arbiter.sv
// FP write-back arbiter. It merges FPU results and LSU FP-load data onto the
// single write port of the FP register file. Arbitration is round-robin and
// the write port is registered. A per-register pending scoreboard lets the
// issue stage stall on read-after-write hazards.
module brq_fp_wb_arbiter #(
  parameter int DataWidth = 32,
  parameter int NumRegs   = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 fpu_valid_i,
  output logic                 fpu_ready_o,
  input  logic [4:0]           fpu_rd_i,
  input  logic [DataWidth-1:0] fpu_wdata_i,
  input  logic                 lsu_valid_i,
  output logic                 lsu_ready_o,
  input  logic [4:0]           lsu_rd_i,
  input  logic [DataWidth-1:0] lsu_wdata_i,
  input  logic                 issue_valid_i,
  input  logic [4:0]           issue_rd_i,
  input  logic [2:0][4:0]      rs_addr_i,
  input  logic [2:0]           rs_used_i,
  output logic                 hazard_o,
  output logic [4:0]           waddr_a_o,
  output logic [DataWidth-1:0] wdata_a_o,
  output logic                 we_a_o,
  output logic [NumRegs-1:0]   pending_o
);

  // rr_q == 0 means the FPU wins the next contended cycle.
  logic               rr_q;
  logic [NumRegs-1:0] pending_q;
  logic [NumRegs-1:0] pending_d;
  logic [NumRegs-1:0] set_vec;
  logic [NumRegs-1:0] clr_vec;
  logic               fpu_grant;
  logic               lsu_grant;

  // Grant decode: a lone requester always wins, and rr_q settles a tie.
  // Reset masks both grants, so nothing is accepted while rst_i is high.
  always_comb begin
    fpu_grant = 1'b0;
    lsu_grant = 1'b0;
    if (!rst_i) begin
      fpu_grant = fpu_valid_i & (~lsu_valid_i | ~rr_q);
      lsu_grant = lsu_valid_i & (~fpu_valid_i |  rr_q);
    end
  end

  assign fpu_ready_o = fpu_grant;
  assign lsu_ready_o = lsu_grant;

  // Round-robin pointer: after any grant, the other source gets priority.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q <= 1'b0;
    end else if (fpu_grant) begin
      rr_q <= 1'b1;
    end else if (lsu_grant) begin
      rr_q <= 1'b0;
    end
  end

  // Registered write port. Address and data hold when no transfer occurs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      we_a_o    <= 1'b0;
      waddr_a_o <= '0;
      wdata_a_o <= '0;
    end else begin
      we_a_o <= fpu_grant | lsu_grant;
      if (fpu_grant) begin
        waddr_a_o <= fpu_rd_i;
        wdata_a_o <= fpu_wdata_i;
      end else if (lsu_grant) begin
        waddr_a_o <= lsu_rd_i;
        wdata_a_o <= lsu_wdata_i;
      end
    end
  end

  // Scoreboard update: clear on a register file write, set on issue.
  // Set is applied last, so it wins when both hit the same register.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    for (int i = 0; i < NumRegs; i++) begin
      set_vec[i] = issue_valid_i & (issue_rd_i == 5'(i));
      clr_vec[i] = we_a_o & (waddr_a_o == 5'(i));
    end
    pending_d = (pending_q & ~clr_vec) | set_vec;
  end

  // Scoreboard state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // Hazard check reads only registered state, so there is no write bypass.
  // A consumer is released the cycle after the write, when the file holds it.
  always_comb begin
    hazard_o = 1'b0;
    if (!rst_i) begin
      for (int k = 0; k < 3; k++) begin
        if (rs_used_i[k] && pending_q[rs_addr_i[k]]) begin
          hazard_o = 1'b1;
        end
      end
    end
  end

  assign pending_o = pending_q;

endmodule

// File: tb/tb_brq_fp_wb_arbiter.sv
// Directed testbench for brq_fp_wb_arbiter with hand-computed expectations.
module tb_brq_fp_wb_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        fpu_valid;
  logic        fpu_ready;
  logic [4:0]  fpu_rd;
  logic [31:0] fpu_wdata;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_wdata;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [2:0][4:0] rs_addr;
  logic [2:0]  rs_used;
  logic        hazard;
  logic [4:0]  waddr_a;
  logic [31:0] wdata_a;
  logic        we_a;
  logic [31:0] pending;

  int checkCount = 0;
  int errorCount = 0;

  brq_fp_wb_arbiter #(.DataWidth(32), .NumRegs(32)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .fpu_valid_i  (fpu_valid),
    .fpu_ready_o  (fpu_ready),
    .fpu_rd_i     (fpu_rd),
    .fpu_wdata_i  (fpu_wdata),
    .lsu_valid_i  (lsu_valid),
    .lsu_ready_o  (lsu_ready),
    .lsu_rd_i     (lsu_rd),
    .lsu_wdata_i  (lsu_wdata),
    .issue_valid_i(issue_valid),
    .issue_rd_i   (issue_rd),
    .rs_addr_i    (rs_addr),
    .rs_used_i    (rs_used),
    .hazard_o     (hazard),
    .waddr_a_o    (waddr_a),
    .wdata_a_o    (wdata_a),
    .we_a_o       (we_a),
    .pending_o    (pending)
  );

  // 10-time-unit clock.
  always #5 clk_i = ~clk_i;

  // Count one comparison and report it if the observed value differs.
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic applyStimulus();
    @(posedge clk_i);
    #1;
  endtask

  logic [31:0] expData [4];
  logic [4:0]  expAddr [4];

  initial begin
    rst_i       = 1'b1;
    fpu_valid   = 1'b1;
    fpu_rd      = 5'd1;
    fpu_wdata   = 32'hA000_0000;
    lsu_valid   = 1'b1;
    lsu_rd      = 5'd2;
    lsu_wdata   = 32'hB000_0000;
    issue_valid = 1'b0;
    issue_rd    = 5'd0;
    rs_addr     = '0;
    rs_used     = 3'b000;
    #1;
    checkOutput("rst_fpu_ready", 64'(fpu_ready), 64'd0);
    checkOutput("rst_lsu_ready", 64'(lsu_ready), 64'd0);
    checkOutput("rst_hazard", 64'(hazard), 64'd0);
    applyStimulus();
    checkOutput("rst_we", 64'(we_a), 64'd0);
    checkOutput("rst_waddr", 64'(waddr_a), 64'd0);
    checkOutput("rst_wdata", 64'(wdata_a), 64'd0);
    checkOutput("rst_pending", 64'(pending), 64'd0);
    applyStimulus();
    checkOutput("rst2_lsu_ready", 64'(lsu_ready), 64'd0);

    // Contention: grants alternate FPU, LSU, FPU, LSU starting with the FPU.
    rst_i = 1'b0;
    expAddr[0] = 5'd1; expData[0] = 32'hA000_0000;
    expAddr[1] = 5'd2; expData[1] = 32'hB000_0000;
    expAddr[2] = 5'd1; expData[2] = 32'hA000_0001;
    expAddr[3] = 5'd2; expData[3] = 32'hB000_0001;
    for (int i = 0; i < 4; i++) begin
      #1;
      checkOutput($sformatf("cont_fpu_ready%0d", i), 64'(fpu_ready), 64'((i % 2) == 0));
      checkOutput($sformatf("cont_lsu_ready%0d", i), 64'(lsu_ready), 64'((i % 2) == 1));
      applyStimulus();
      if ((i % 2) == 0) fpu_wdata = 32'hA000_0001;
      else              lsu_wdata = 32'hB000_0001;
      if (i == 3) begin
        fpu_valid = 1'b0;
        lsu_valid = 1'b0;
      end
      checkOutput($sformatf("cont_we%0d", i), 64'(we_a), 64'd1);
      checkOutput($sformatf("cont_waddr%0d", i), 64'(waddr_a), 64'(expAddr[i]));
      checkOutput($sformatf("cont_wdata%0d", i), 64'(wdata_a), 64'(expData[i]));
    end
    applyStimulus();
    checkOutput("cont_we_idle", 64'(we_a), 64'd0);
    checkOutput("cont_waddr_hold", 64'(waddr_a), 64'd2);
    checkOutput("cont_pending_zero", 64'(pending), 64'd0);

    // Single source: FPU rd=5.
    fpu_valid = 1'b1;
    fpu_rd    = 5'd5;
    fpu_wdata = 32'h41A0_0000;
    #1;
    checkOutput("single_fpu_ready", 64'(fpu_ready), 64'd1);
    checkOutput("single_lsu_ready", 64'(lsu_ready), 64'd0);
    applyStimulus();
    fpu_valid = 1'b0;
    checkOutput("single_we", 64'(we_a), 64'd1);
    checkOutput("single_waddr", 64'(waddr_a), 64'd5);
    checkOutput("single_wdata", 64'(wdata_a), 64'h41A0_0000);
    applyStimulus();
    checkOutput("single_we_drop", 64'(we_a), 64'd0);
    checkOutput("single_wdata_hold", 64'(wdata_a), 64'h41A0_0000);

    // Scoreboard: issue rd=6, then LSU writes rd=6.
    issue_valid = 1'b1;
    issue_rd    = 5'd6;
    applyStimulus();
    issue_valid = 1'b0;
    rs_addr[0]  = 5'd6;
    rs_addr[1]  = 5'd9;
    rs_addr[2]  = 5'd10;
    rs_used     = 3'b001;
    #1;
    checkOutput("sb_pending6", 64'(pending), 64'h40);
    checkOutput("sb_hazard_rs1", 64'(hazard), 64'd1);
    rs_used = 3'b110;
    #1;
    checkOutput("sb_hazard_unused", 64'(hazard), 64'd0);
    rs_addr[1] = 5'd6;
    #1;
    checkOutput("sb_hazard_rs2", 64'(hazard), 64'd1);
    rs_addr[1] = 5'd9;
    rs_used    = 3'b001;
    lsu_valid  = 1'b1;
    lsu_rd     = 5'd6;
    lsu_wdata  = 32'h3F80_0000;
    #1;
    checkOutput("sb_lsu_ready", 64'(lsu_ready), 64'd1);
    checkOutput("sb_hazard_before", 64'(hazard), 64'd1);
    applyStimulus();
    lsu_valid = 1'b0;
    checkOutput("sb_we", 64'(we_a), 64'd1);
    checkOutput("sb_waddr", 64'(waddr_a), 64'd6);
    checkOutput("sb_hazard_we_cycle", 64'(hazard), 64'd1);
    applyStimulus();
    checkOutput("sb_hazard_cleared", 64'(hazard), 64'd0);
    checkOutput("sb_pending_cleared", 64'(pending), 64'd0);

    // Simultaneous set and clear on rd=3: set wins.
    fpu_valid = 1'b1;
    fpu_rd    = 5'd3;
    fpu_wdata = 32'h4040_0000;
    applyStimulus();
    fpu_valid   = 1'b0;
    issue_valid = 1'b1;
    issue_rd    = 5'd3;
    checkOutput("ss_we", 64'(we_a), 64'd1);
    checkOutput("ss_waddr", 64'(waddr_a), 64'd3);
    applyStimulus();
    issue_valid = 1'b0;
    rs_addr[2]  = 5'd3;
    rs_used     = 3'b100;
    #1;
    checkOutput("ss_pending3", 64'(pending), 64'h8);
    checkOutput("ss_hazard_rs3", 64'(hazard), 64'd1);

    // Mid-operation reset: the pending FPU rd=7 grant is discarded.
    fpu_valid = 1'b1;
    fpu_rd    = 5'd7;
    fpu_wdata = 32'h7777_7777;
    #1;
    checkOutput("mr_ready_before", 64'(fpu_ready), 64'd1);
    rst_i = 1'b1;
    #1;
    checkOutput("mr_ready_in_reset", 64'(fpu_ready), 64'd0);
    checkOutput("mr_hazard_in_reset", 64'(hazard), 64'd0);
    applyStimulus();
    rst_i     = 1'b0;
    fpu_valid = 1'b0;
    checkOutput("mr_we", 64'(we_a), 64'd0);
    checkOutput("mr_waddr", 64'(waddr_a), 64'd0);
    checkOutput("mr_pending", 64'(pending), 64'd0);
    applyStimulus();
    checkOutput("mr_no_late_write", 64'(we_a), 64'd0);

    // After reset the FPU again wins a tie.
    fpu_valid = 1'b1;
    lsu_valid = 1'b1;
    #1;
    checkOutput("mr_tie_fpu", 64'(fpu_ready), 64'd1);
    checkOutput("mr_tie_lsu", 64'(lsu_ready), 64'd0);
    fpu_valid = 1'b0;
    lsu_valid = 1'b0;
    applyStimulus();

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
